// File: rtl/mul_pkg.sv
// mul_pkg: shared funct3 codes, state encoding, signedness codes and result formatting
package mul_pkg;
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [1:0] SGN_SS = 2'b11;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_UU = 2'b00;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    function automatic logic [63:0] fmt_result(input logic is_w, input logic sel_hi,
                                               input logic [63:0] hi, input logic [63:0] lo);
        return is_w ? {{32{lo[31]}}, lo[31:0]} : sel_hi ? hi : lo;
    endfunction
endpackage

// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if: pipeline op/result handshakes plus the multiplier handshake
interface mul_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_is_w;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        m_valid;
    logic        m_flush;
    logic        m_mulw;
    logic [1:0]  m_signed;
    logic [63:0] m_multiplicand;
    logic [63:0] m_multiplier;
    logic        m_ready;
    logic [63:0] m_result_hi;
    logic [63:0] m_result_lo;
    modport master (
        output in_valid, in_op, in_is_w, in_src1, in_src2, out_ready, m_ready, m_result_hi, m_result_lo,
        input  in_ready, out_valid, out_data, m_valid, m_flush, m_mulw, m_signed, m_multiplicand, m_multiplier
    );
    modport slave (
        input  in_valid, in_op, in_is_w, in_src1, in_src2, out_ready, m_ready, m_result_hi, m_result_lo,
        output in_ready, out_valid, out_data, m_valid, m_flush, m_mulw, m_signed, m_multiplicand, m_multiplier
    );
endinterface

// File: rtl/mul_result_cache.sv
// mul_result_cache: one-entry product cache keyed on operands, width and signedness
module mul_result_cache #(
    parameter bit EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic [1:0]  sgn,
    input  logic        is_w,
    input  logic        sel_hi,
    input  logic        we,
    input  logic [63:0] w_src1,
    input  logic [63:0] w_src2,
    input  logic [1:0]  w_sgn,
    input  logic        w_is_w,
    input  logic [63:0] w_hi,
    input  logic [63:0] w_lo,
    output logic        hit,
    output logic [63:0] hi,
    output logic [63:0] lo
);
    logic [63:0] k_src1, k_src2;
    logic [1:0]  k_sgn;
    logic        k_is_w, valid;
    // the low product half is signedness-independent, so only hi selections compare sgn
    assign hit = EN && valid && src1 == k_src1 && src2 == k_src2 && is_w == k_is_w && (!sel_hi || sgn == k_sgn);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            k_src1 <= '0;
            k_src2 <= '0;
            k_sgn  <= '0;
            k_is_w <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (we) begin
            valid  <= 1'b1;
            k_src1 <= w_src1;
            k_src2 <= w_src2;
            k_sgn  <= w_sgn;
            k_is_w <= w_is_w;
            hi     <= w_hi;
            lo     <= w_lo;
        end
    end
endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: execute-stage sequencer for the shared Booth multiplier with a one-entry result cache
module mul_ctrl import mul_pkg::*; #(
    parameter bit CACHE_EN = 1,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    mul_ctrl_if.slave         bus,
    output logic [PERF_W-1:0] perf_busy_cycles
);
    state_t      state;
    logic [63:0] src1, src2, data, c_hi, c_lo;
    logic [1:0]  sgn, d_sgn;
    logic        is_w, sel_hi, seen_busy, d_hi, hit, done_mul;
    assign d_hi  = !bus.in_is_w && bus.in_op inside {MULH, MULHSU, MULHU};
    assign d_sgn = bus.in_is_w ? SGN_SS : bus.in_op == MULHSU ? SGN_SU : bus.in_op == MULHU ? SGN_UU : SGN_SS;
    // m_ready is only trusted once it has been seen low after the accept
    assign done_mul = state == WAIT && seen_busy && bus.m_ready && !flush_i;
    mul_result_cache #(.EN(CACHE_EN)) u_cache (
        .clk(clk), .rst(rst),
        .src1(bus.in_src1), .src2(bus.in_src2), .sgn(d_sgn), .is_w(bus.in_is_w), .sel_hi(d_hi),
        .we(done_mul), .w_src1(src1), .w_src2(src2), .w_sgn(sgn), .w_is_w(is_w),
        .w_hi(bus.m_result_hi), .w_lo(bus.m_result_lo),
        .hit(hit), .hi(c_hi), .lo(c_lo)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            src1             <= '0;
            src2             <= '0;
            sgn              <= '0;
            is_w             <= 1'b0;
            sel_hi           <= 1'b0;
            seen_busy        <= 1'b0;
            data             <= '0;
            perf_busy_cycles <= '0;
        end else begin
            if ((state == ISSUE || state == WAIT) && !(&perf_busy_cycles))
                perf_busy_cycles <= perf_busy_cycles + PERF_W'(1);
            if (flush_i) state <= IDLE;
            else unique case (state)
                IDLE: if (bus.in_valid) begin
                    src1   <= bus.in_src1;
                    src2   <= bus.in_src2;
                    sgn    <= d_sgn;
                    is_w   <= bus.in_is_w;
                    sel_hi <= d_hi;
                    state  <= hit ? DONE : ISSUE;
                    if (hit) data <= fmt_result(bus.in_is_w, d_hi, c_hi, c_lo);
                end
                ISSUE: if (bus.m_ready) begin
                    state     <= WAIT;
                    seen_busy <= 1'b0;
                end
                WAIT: if (!bus.m_ready) seen_busy <= 1'b1;
                else if (seen_busy) begin
                    data  <= fmt_result(is_w, sel_hi, bus.m_result_hi, bus.m_result_lo);
                    state <= DONE;
                end
                DONE: if (bus.out_ready) state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready       = state == IDLE && !flush_i;
    assign bus.out_valid      = state == DONE;
    assign bus.out_data       = data;
    assign bus.m_valid        = state == ISSUE;
    assign bus.m_flush        = flush_i && (state == ISSUE || state == WAIT);
    assign bus.m_mulw         = is_w;
    assign bus.m_signed       = sgn;
    assign bus.m_multiplicand = src1;
    assign bus.m_multiplier   = src2;
endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
Execute-stage sequencer for the shared 64x64 radix-4 Booth multiplier. It accepts one RV64M multiply op from the pipeline over a valid/ready handshake and decodes it into the multiplier's signedness and width controls. It runs the multiplier handshake, detects completion, selects and formats the result, and holds it until the writeback stage accepts it. A one-entry result cache returns the paired half of the previous product (MULH followed by MUL on the same operands) without restarting the multiplier.

Parameters:
CACHE_EN, 1, 1 enables the one-entry result cache; 0 forces every op through the multiplier.
PERF_W, 32, width of the busy-cycle profiling counter.

Ports:
clk  in  1  clock.
rst  in  1  reset, synchronous, active-high.
flush_i  in  1  pipeline flush; kills any in-flight op.
in_valid  in  1  op offered.
in_ready  out  1  controller can accept an op.
in_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other values are treated as MUL.
in_is_w  in  1  MULW; forces the low-result path and ignores in_op.
in_src1  in  64  rs1, the multiplicand.
in_src2  in  64  rs2, the multiplier.
out_valid  out  1  result held.
out_ready  in  1  writeback accepts the result.
out_data  out  64  formatted result.
m_valid  out  1  multiplier mul_valid.
m_flush  out  1  multiplier flush.
m_mulw  out  1  multiplier mulw.
m_signed  out  2  multiplier mul_signed.
m_multiplicand  out  64  multiplier operand.
m_multiplier  out  64  multiplier operand.
m_ready  in  1  multiplier mul_ready, a level signal; it drops the cycle after accept and rises together with valid result_hi/lo.
m_result_hi  in  64  high product.
m_result_lo  in  64  low product.
perf_busy_cycles  out  PERF_W  count of cycles spent in ISSUE or WAIT; saturates at all-ones.

Behaviour:
- Reset: state IDLE, cache invalid, perf counter 0. All outputs are 0 except in_ready, which is 1.
- State IDLE:
  - in_ready=1.
  - When in_valid is high, latch op, srcs and the decoded controls.
  - Cache hit: go to DONE the next cycle with the cached data.
  - Miss: go to ISSUE.
- State ISSUE:
  - m_valid=1; operands and controls come from the latched registers and stay stable until accepted.
  - m_valid & m_ready: go to WAIT and clear seen_busy.
- State WAIT:
  - m_valid=0.
  - m_ready=0: set seen_busy.
  - seen_busy & m_ready: capture the formatted result into out_data, update the cache, go to DONE.
- State DONE:
  - out_valid=1; out_data is held stable.
  - out_ready: go to IDLE. in_ready is 0 in that same cycle, so there is no same-cycle re-accept.
- Decode to m_signed:
  - MUL/MULH: 11.
  - MULHSU: 10.
  - MULHU: 00.
  - W ops: 11 with m_mulw=1.
- Result format:
  - MUL: lo.
  - MULH/MULHSU/MULHU: hi.
  - W ops: {32 copies of lo[31], lo[31:0]}.
- Cache:
  - Stores {src1, src2, m_signed, is_w, hi, lo, valid}.
  - Hit requires equal src1, src2 and is_w, plus equal m_signed when the new op selects hi.
  - Low-result ops ignore signedness, since the low 64 bits of the product are independent of it.
  - Only a completed multiplier run writes the cache; cache hits do not rewrite it.
- flush_i, highest priority after rst:
  - Next state is IDLE.
  - m_flush=1 combinationally in that cycle when in ISSUE or WAIT.
  - out_valid drops the next cycle; a result held in DONE is discarded.
  - No cache update; the cache stays valid.
  - flush_i together with in_valid in IDLE: the op is not accepted.
- After a flush, the multiplier holds m_ready low for one or more cycles; ISSUE simply waits, and no timeout exists.
- rst mid-operation: return to reset values; m_flush is not required.
- Perf counter increments on every ISSUE/WAIT cycle and is never cleared by flush.

Decomposition:
- Shared package, mul_pkg:
  - funct3 localparams MUL/MULH/MULHSU/MULHU.
  - State encoding IDLE/ISSUE/WAIT/DONE.
  - m_signed encodings SS=11, SU=10, UU=00.
- One natural sub-module, mul_result_cache: key compare, hit logic and storage for the cached product.

Test Plan:
- MULH, src1=src2=0xFFFFFFFFFFFFFFFF -> m_signed=11; out_data=0x0000000000000000 after m_ready rises; perf counter > 0.
- MULHU, same operands -> m_signed=00; out_data=0xFFFFFFFFFFFFFFFE.
- MULHSU, src1=0xFFFFFFFFFFFFFFFF, src2=0xFFFFFFFFFFFFFFFF -> m_signed=10; out_data=0xFFFFFFFFFFFFFFFF.
- MULW, src1=0x7FFFFFFF, src2=2 -> m_mulw=1; out_data=0xFFFFFFFFFFFFFFFE.
- MULH 3x5 then MUL 3x5 -> second op produces no m_valid pulse and reaches DONE one cycle after accept with out_data=15. With CACHE_EN=0, the second op issues to the multiplier.
- flush_i pulsed two cycles after the ISSUE handshake -> m_flush=1 that cycle, IDLE next, no out_valid. The next op (MUL 7x6) completes with 42 and returns no stale data.
- DONE with out_ready held low for 5 cycles -> out_valid and out_data stable throughout, in_ready=0.
